// File: rtl/sw_alloc_nx1.sv
`default_nettype none
// ============================================================================
// Module   : sw_alloc_nx1
// Purpose  : N-input to 1-output wormhole switch allocator. Head flits are
//            arbitrated round-robin. The output then stays locked to the
//            winning input until that packet's tail flit is written into the
//            downstream output FIFO.
// Ports    :
//   clk           clock; all state updates on the rising edge
//   rstn          synchronous active-low reset
//   Valid_i[N]    per-input flit valid
//   Data_i[N*DW]  input flits; input k occupies [k*DW +: DW]
//   Ready_o[N]    per-input accept (transfer = Valid_i[k] & Ready_o[k])
//   FifoFull_i    output FIFO full
//   FifoWrData_o  write data to the output FIFO (zero when nothing selected)
//   FifoWr_o      write strobe to the output FIFO
//   Occupy_o      output is locked to a packet
//   GrantIdx_o    owner index while locked, 0 when idle
//   ProtoErr_o[N] sticky per-input protocol-error flags
//   ErrClr_i      clears all ProtoErr_o bits (a same-cycle set wins)
//   PktCnt_o      count of tail flits written, wraps modulo 2^CW
// Revision : 1.0 - initial release
// ============================================================================
module sw_alloc_nx1 #(
  parameter  int N  = 4,
  parameter  int DW = 32,
  parameter  int CW = 16,
  localparam int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    Valid_i,
  input  logic [N*DW-1:0] Data_i,
  output logic [N-1:0]    Ready_o,
  input  logic            FifoFull_i,
  output logic [DW-1:0]   FifoWrData_o,
  output logic            FifoWr_o,
  output logic            Occupy_o,
  output logic [GW-1:0]   GrantIdx_o,
  output logic [N-1:0]    ProtoErr_o,
  input  logic            ErrClr_i,
  output logic [CW-1:0]   PktCnt_o
);

  localparam logic [1:0] c_HEAD = 2'b00;
  localparam logic [1:0] c_TAIL = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_owner;
  logic [GW-1:0]   r_prio;
  logic [N-1:0]    r_protoErr;
  logic [CW-1:0]   r_pktCnt;

  logic [DW-1:0]   w_flit [N];
  logic [1:0]      w_type [N];
  logic [N-1:0]    w_eligible;
  logic [N-1:0]    w_isOwner;
  logic [N-1:0]    w_errSet;
  logic            w_found;
  logic [GW-1:0]   w_winner;
  logic [GW-1:0]   w_prioNext;
  logic            w_tailWr;

  // Per-input flit decode and protocol-error detection.
  for (genvar k = 0; k < N; k++) begin : g_in
    assign w_flit[k]     = Data_i[k*DW +: DW];
    assign w_type[k]     = w_flit[k][DW-1 -: 2];
    assign w_eligible[k] = Valid_i[k] && (w_type[k] == c_HEAD);
    assign w_isOwner[k]  = (r_state == ST_LOCKED) && (r_owner == GW'(k));
    // A non-head flit with no packet open for it stalls and is flagged; a
    // head from the current owner is forwarded anyway but still flagged.
    assign w_errSet[k]   = (Valid_i[k] && (w_type[k] != c_HEAD) && !w_isOwner[k]) ||
                           (w_isOwner[k] && FifoWr_o && (w_type[k] == c_HEAD));
  end

  // Round-robin search starting at r_prio, wrapping past N-1 back to 0.
  always_comb begin
    int idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(r_prio) + off;
      if (idx >= N) idx = idx - N;
      if (!w_found && w_eligible[idx]) begin
        w_found  = 1'b1;
        w_winner = idx[GW-1:0];
      end
    end
  end

  assign w_prioNext = (w_winner == GW'(N-1)) ? '0 : w_winner + 1'b1;

  // Output path. Everything is forced quiet while reset is held so that a
  // half-delivered packet cannot leak into the FIFO during reset.
  always_comb begin
    Ready_o      = '0;
    FifoWr_o     = 1'b0;
    FifoWrData_o = '0;
    if (rstn) begin
      if (r_state == ST_LOCKED) begin
        Ready_o[r_owner] = ~FifoFull_i;
        FifoWr_o         = Valid_i[r_owner] & ~FifoFull_i;
        FifoWrData_o     = w_flit[r_owner];
      end else if (w_found) begin
        Ready_o[w_winner] = ~FifoFull_i;
        FifoWr_o          = ~FifoFull_i;
        FifoWrData_o      = w_flit[w_winner];
      end
    end
  end

  assign w_tailWr = (r_state == ST_LOCKED) && FifoWr_o && (w_type[r_owner] == c_TAIL);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_prio     <= '0;
      r_protoErr <= '0;
      r_pktCnt   <= '0;
    end else begin
      // Set has priority over clear on the same bit.
      r_protoErr <= (ErrClr_i ? '0 : r_protoErr) | w_errSet;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !FifoFull_i) begin
            r_state <= ST_LOCKED;
            r_owner <= w_winner;
            r_prio  <= w_prioNext;
          end
        end
        ST_LOCKED: begin
          // Release right after the tail so a new head can win next cycle.
          if (w_tailWr) begin
            r_state  <= ST_IDLE;
            r_pktCnt <= r_pktCnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Occupy_o   = (r_state == ST_LOCKED);
  assign GrantIdx_o = (r_state == ST_LOCKED) ? r_owner : '0;
  assign ProtoErr_o = r_protoErr;
  assign PktCnt_o   = r_pktCnt;

endmodule
`default_nettype wire

// File: tb/tb_sw_alloc_nx1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sw_alloc_nx1
// Purpose  : Directed self-checking bench for sw_alloc_nx1 (N=4, DW=32, CW=4).
//            Inputs change 1ns after the rising edge; outputs are sampled on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sw_alloc_nx1;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    Valid_i;
  logic [N*DW-1:0] Data_i;
  logic [N-1:0]    Ready_o;
  logic            FifoFull_i;
  logic [DW-1:0]   FifoWrData_o;
  logic            FifoWr_o;
  logic            Occupy_o;
  logic [GW-1:0]   GrantIdx_o;
  logic [N-1:0]    ProtoErr_o;
  logic            ErrClr_i;
  logic [CW-1:0]   PktCnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sw_alloc_nx1 #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .Valid_i      (Valid_i),
    .Data_i       (Data_i),
    .Ready_o      (Ready_o),
    .FifoFull_i   (FifoFull_i),
    .FifoWrData_o (FifoWrData_o),
    .FifoWr_o     (FifoWr_o),
    .Occupy_o     (Occupy_o),
    .GrantIdx_o   (GrantIdx_o),
    .ProtoErr_o   (ProtoErr_o),
    .ErrClr_i     (ErrClr_i),
    .PktCnt_o     (PktCnt_o)
  );

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic setIn(input int k, input logic v, input logic [DW-1:0] f);
    Valid_i[k]         = v;
    Data_i[k*DW +: DW] = f;
  endtask

  task automatic clearIn();
    Valid_i = '0;
    Data_i  = '0;
  endtask

  task automatic cycStart();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0; ErrClr_i = 1'b0; FifoFull_i = 1'b0;
    clearIn();
    setIn(0, 1'b1, mk(2'b00, 30'h1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (Ready_o !== 4'b0000) begin failures++; $display("FAIL rst_ready: got %b want 0000", Ready_o); end
    checks++; if (FifoWr_o !== 1'b0) begin failures++; $display("FAIL rst_wr: got %b want 0", FifoWr_o); end
    checks++; if (Occupy_o !== 1'b0) begin failures++; $display("FAIL rst_occupy: got %b want 0", Occupy_o); end
    checks++; if (GrantIdx_o !== 2'd0) begin failures++; $display("FAIL rst_grant: got %0d want 0", GrantIdx_o); end
    checks++; if (PktCnt_o !== 4'd0) begin failures++; $display("FAIL rst_pktcnt: got %0d want 0", PktCnt_o); end
    checks++; if (ProtoErr_o !== 4'b0000) begin failures++; $display("FAIL rst_err: got %b want 0000", ProtoErr_o); end
    cycStart();
    rstn = 1'b1;
    clearIn();
  endtask

  // --------------------------------------------------------------------------
  function automatic logic [DW-1:0] rrFlit(input int k, input int j);
    logic [1:0] t;
    t = (j == 0) ? 2'b00 : ((j == 1) ? 2'b01 : 2'b11);
    return mk(t, 30'(k*16 + j));
  endfunction

  task automatic test_round_robin();
    int ptr [N];
    logic [DW-1:0] expQ [$];
    logic expWr;
    for (int k = 0; k < N; k++) begin
      ptr[k] = 0;
      for (int j = 0; j < 3; j++) expQ.push_back(rrFlit(k, j));
    end
    for (int c = 0; c < 14; c++) begin
      cycStart();
      for (int k = 0; k < N; k++) begin
        if (ptr[k] < 3) setIn(k, 1'b1, rrFlit(k, ptr[k]));
        else            setIn(k, 1'b0, '0);
      end
      @(negedge clk);
      expWr = (c < 12);
      checks++; if (FifoWr_o !== expWr) begin failures++; $display("FAIL rr_wr c=%0d: got %b want %b", c, FifoWr_o, expWr); end
      if (c < 12) begin
        checks++; if (FifoWrData_o !== expQ[c]) begin failures++; $display("FAIL rr_data c=%0d: got %h want %h", c, FifoWrData_o, expQ[c]); end
      end
      for (int k = 0; k < N; k++) if (Valid_i[k] && Ready_o[k]) ptr[k]++;
    end
    checks++; if (PktCnt_o !== 4'd4) begin failures++; $display("FAIL rr_pktcnt: got %0d want 4", PktCnt_o); end
    checks++; if (ProtoErr_o !== 4'b0000) begin failures++; $display("FAIL rr_err: got %b want 0000", ProtoErr_o); end
    cycStart();
    clearIn();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_lock_hold();
    cycStart();
    setIn(2, 1'b1, 32'h0000_00AA);
    @(negedge clk);
    checks++; if (Ready_o !== 4'b0100) begin failures++; $display("FAIL lk_head_ready: got %b want 0100", Ready_o); end
    checks++; if (FifoWrData_o !== 32'h0000_00AA) begin failures++; $display("FAIL lk_head_data: got %h want 000000aa", FifoWrData_o); end

    cycStart();
    setIn(2, 1'b1, 32'h4000_00BB);
    setIn(1, 1'b1, 32'h0000_0011);
    @(negedge clk);
    checks++; if (Ready_o !== 4'b0100) begin failures++; $display("FAIL lk_body_ready: got %b want 0100", Ready_o); end
    checks++; if (GrantIdx_o !== 2'd2) begin failures++; $display("FAIL lk_body_grant: got %0d want 2", GrantIdx_o); end
    checks++; if (FifoWrData_o !== 32'h4000_00BB) begin failures++; $display("FAIL lk_body_data: got %h want 400000bb", FifoWrData_o); end

    cycStart();
    setIn(2, 1'b1, 32'hC000_00CC);
    @(negedge clk);
    checks++; if (Ready_o !== 4'b0100) begin failures++; $display("FAIL lk_tail_ready: got %b want 0100", Ready_o); end
    checks++; if (GrantIdx_o !== 2'd2) begin failures++; $display("FAIL lk_tail_grant: got %0d want 2", GrantIdx_o); end
    checks++; if (FifoWrData_o !== 32'hC000_00CC) begin failures++; $display("FAIL lk_tail_data: got %h want c00000cc", FifoWrData_o); end

    cycStart();
    setIn(2, 1'b0, '0);
    @(negedge clk);
    checks++; if (Occupy_o !== 1'b0) begin failures++; $display("FAIL lk_release: got %b want 0", Occupy_o); end
    checks++; if (Ready_o !== 4'b0010) begin failures++; $display("FAIL lk_next_ready: got %b want 0010", Ready_o); end
    checks++; if (FifoWrData_o !== 32'h0000_0011) begin failures++; $display("FAIL lk_next_data: got %h want 00000011", FifoWrData_o); end

    cycStart();
    setIn(1, 1'b1, 32'hC000_0012);
    @(negedge clk);
    checks++; if (GrantIdx_o !== 2'd1) begin failures++; $display("FAIL lk_next_grant: got %0d want 1", GrantIdx_o); end
    checks++; if (FifoWr_o !== 1'b1) begin failures++; $display("FAIL lk_next_wr: got %b want 1", FifoWr_o); end
    cycStart();
    clearIn();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [DW-1:0] bp [5];
    logic full;
    int p;
    bp[0] = mk(2'b00, 30'h100); bp[1] = mk(2'b01, 30'h101); bp[2] = mk(2'b10, 30'h102);
    bp[3] = mk(2'b01, 30'h103); bp[4] = mk(2'b11, 30'h104);
    p = 0;
    for (int c = 0; c < 10; c++) begin
      cycStart();
      full = (c >= 2) && (c <= 6);
      FifoFull_i = full;
      setIn(0, 1'b1, bp[p]);
      @(negedge clk);
      checks++; if (FifoWr_o !== !full) begin failures++; $display("FAIL bp_wr c=%0d: got %b want %b", c, FifoWr_o, !full); end
      checks++; if (Ready_o !== (full ? 4'b0000 : 4'b0001)) begin failures++; $display("FAIL bp_ready c=%0d: got %b", c, Ready_o); end
      if (!full) begin
        checks++; if (FifoWrData_o !== bp[p]) begin failures++; $display("FAIL bp_data c=%0d: got %h want %h", c, FifoWrData_o, bp[p]); end
        p++;
      end
      if (c >= 1) begin
        checks++; if (Occupy_o !== 1'b1) begin failures++; $display("FAIL bp_occupy c=%0d: got %b want 1", c, Occupy_o); end
      end
    end
    cycStart();
    clearIn();
    FifoFull_i = 1'b0;
    @(negedge clk);
    checks++; if (Occupy_o !== 1'b0) begin failures++; $display("FAIL bp_release: got %b want 0", Occupy_o); end
    checks++; if (PktCnt_o !== 4'd7) begin failures++; $display("FAIL bp_pktcnt: got %0d want 7", PktCnt_o); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_proto_err();
    cycStart();
    setIn(3, 1'b1, mk(2'b01, 30'h33));
    @(negedge clk);
    checks++; if (Ready_o !== 4'b0000) begin failures++; $display("FAIL pe_ready: got %b want 0000", Ready_o); end
    checks++; if (FifoWr_o !== 1'b0) begin failures++; $display("FAIL pe_wr: got %b want 0", FifoWr_o); end
    cycStart();
    clearIn();
    @(negedge clk);
    checks++; if (ProtoErr_o !== 4'b1000) begin failures++; $display("FAIL pe_set: got %b want 1000", ProtoErr_o); end
    cycStart();
    ErrClr_i = 1'b1;
    cycStart();
    ErrClr_i = 1'b0;
    @(negedge clk);
    checks++; if (ProtoErr_o !== 4'b0000) begin failures++; $display("FAIL pe_clr: got %b want 0000", ProtoErr_o); end

    // Clear and set on the same bit in one cycle: the set must win.
    cycStart();
    ErrClr_i = 1'b1;
    setIn(3, 1'b1, mk(2'b01, 30'h34));
    cycStart();
    ErrClr_i = 1'b0;
    clearIn();
    @(negedge clk);
    checks++; if (ProtoErr_o !== 4'b1000) begin failures++; $display("FAIL pe_setwins: got %b want 1000", ProtoErr_o); end
    cycStart();
    ErrClr_i = 1'b1;
    cycStart();
    ErrClr_i = 1'b0;
    @(negedge clk);
    checks++; if (ProtoErr_o !== 4'b0000) begin failures++; $display("FAIL pe_clr2: got %b want 0000", ProtoErr_o); end

    // Repeated head from the owner: forwarded, flagged, lock kept.
    cycStart();
    setIn(1, 1'b1, mk(2'b00, 30'h51));
    cycStart();
    setIn(1, 1'b1, mk(2'b00, 30'h52));
    @(negedge clk);
    checks++; if (FifoWrData_o !== mk(2'b00, 30'h52) || FifoWr_o !== 1'b1) begin failures++; $display("FAIL pe_dup_fwd: got wr=%b data=%h want wr=1 data=00000052", FifoWr_o, FifoWrData_o); end
    checks++; if (GrantIdx_o !== 2'd1) begin failures++; $display("FAIL pe_dup_grant: got %0d want 1", GrantIdx_o); end
    cycStart();
    setIn(1, 1'b1, mk(2'b11, 30'h53));
    @(negedge clk);
    checks++; if (ProtoErr_o !== 4'b0010) begin failures++; $display("FAIL pe_dup_err: got %b want 0010", ProtoErr_o); end
    checks++; if (Occupy_o !== 1'b1) begin failures++; $display("FAIL pe_dup_lock: got %b want 1", Occupy_o); end
    cycStart();
    clearIn();
    ErrClr_i = 1'b1;
    @(negedge clk);
    checks++; if (PktCnt_o !== 4'd8) begin failures++; $display("FAIL pe_pktcnt: got %0d want 8", PktCnt_o); end
    cycStart();
    ErrClr_i = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midpkt();
    cycStart();
    setIn(2, 1'b1, mk(2'b00, 30'h62));
    @(negedge clk);
    checks++; if (FifoWr_o !== 1'b1) begin failures++; $display("FAIL rm_head_wr: got %b want 1", FifoWr_o); end
    cycStart();
    setIn(2, 1'b1, mk(2'b01, 30'h63));
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (Ready_o !== 4'b0000 || FifoWr_o !== 1'b0) begin failures++; $display("FAIL rm_quiet: got ready=%b wr=%b want 0000/0", Ready_o, FifoWr_o); end
    cycStart();
    rstn = 1'b1;
    setIn(0, 1'b1, mk(2'b00, 30'h70));
    setIn(2, 1'b1, mk(2'b00, 30'h64));
    @(negedge clk);
    checks++; if (Occupy_o !== 1'b0) begin failures++; $display("FAIL rm_occupy: got %b want 0", Occupy_o); end
    checks++; if (PktCnt_o !== 4'd0) begin failures++; $display("FAIL rm_pktcnt: got %0d want 0", PktCnt_o); end
    checks++; if (Ready_o !== 4'b0001) begin failures++; $display("FAIL rm_winner: got %b want 0001", Ready_o); end
    checks++; if (FifoWrData_o !== mk(2'b00, 30'h70)) begin failures++; $display("FAIL rm_data: got %h want 00000070", FifoWrData_o); end
    cycStart();
    setIn(0, 1'b1, mk(2'b11, 30'h71));
    setIn(2, 1'b0, '0);
    @(negedge clk);
    checks++; if (Occupy_o !== 1'b1 || GrantIdx_o !== 2'd0) begin failures++; $display("FAIL rm_lock: got occ=%b grant=%0d want 1/0", Occupy_o, GrantIdx_o); end
    cycStart();
    clearIn();
    @(negedge clk);
    checks++; if (PktCnt_o !== 4'd1) begin failures++; $display("FAIL rm_pktcnt2: got %0d want 1", PktCnt_o); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_counter_wrap();
    int k;
    cycStart();
    rstn = 1'b0;
    clearIn();
    cycStart();
    rstn = 1'b1;
    for (int p = 0; p < 17; p++) begin
      k = p % N;
      cycStart();
      clearIn();
      setIn(k, 1'b1, mk(2'b00, 30'(p)));
      @(negedge clk);
      checks++; if (FifoWr_o !== 1'b1 || FifoWrData_o !== mk(2'b00, 30'(p))) begin failures++; $display("FAIL cw_head p=%0d: got wr=%b data=%h", p, FifoWr_o, FifoWrData_o); end
      if (p == 16) begin
        checks++; if (PktCnt_o !== 4'd0) begin failures++; $display("FAIL cw_wrap0: got %0d want 0", PktCnt_o); end
      end
      cycStart();
      setIn(k, 1'b1, mk(2'b11, 30'(p)));
      @(negedge clk);
      checks++; if (FifoWr_o !== 1'b1) begin failures++; $display("FAIL cw_tail p=%0d: got %b want 1", p, FifoWr_o); end
    end
    cycStart();
    clearIn();
    @(negedge clk);
    checks++; if (PktCnt_o !== 4'd1) begin failures++; $display("FAIL cw_final: got %0d want 1", PktCnt_o); end
    checks++; if (ProtoErr_o !== 4'b0000) begin failures++; $display("FAIL cw_err: got %b want 0000", ProtoErr_o); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock_hold();
    test_backpressure();
    test_proto_err();
    test_reset_midpkt();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
